// File: rtl/hb_bridge_array.sv
// Multi-channel H-bridge gate driver with per-channel break-before-make sequencing.
// Optional fault sensing on driven legs is enabled by defining HB_FAULT_SENSE_EN.
module hb_bridge_array #(
    parameter int NUM_CH = 4,
    parameter int DEAD_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DEAD_W-1:0]     dead_time,
    input  logic [2*NUM_CH-1:0]   cmd,
`ifdef HB_FAULT_SENSE_EN
    input  logic [NUM_CH-1:0]     sns_a,
    input  logic [NUM_CH-1:0]     sns_b,
    input  logic                  fault_clr,
    output logic [NUM_CH-1:0]     fault,
`endif
    output logic [NUM_CH-1:0]     pa_n,
    output logic [NUM_CH-1:0]     pb_n,
    output logic [NUM_CH-1:0]     na,
    output logic [NUM_CH-1:0]     nb,
    output logic [NUM_CH-1:0]     busy
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_DEAD  = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [1:0] C_COAST = 2'b00;
    localparam logic [1:0] C_FWD   = 2'b01;
    localparam logic [1:0] C_REV   = 2'b10;
    localparam logic [1:0] C_BRK   = 2'b11;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [1:0]        act_q, act_d;
        logic [1:0]        tgt_q, tgt_d;
        logic [DEAD_W-1:0] cnt_q, cnt_d;
        logic [1:0]        c;
        logic [1:0]        drv;
        logic              hold;
        logic              pa_q, pb_q, na_q, nb_q;

        assign c   = cmd[2*i +: 2];
        assign drv = (state_q == S_DRIVE) ? act_q : C_COAST;

        always_comb begin
            state_d = state_q;
            act_d   = act_q;
            tgt_d   = tgt_q;
            cnt_d   = cnt_q;
            if (!enable || hold) begin
                state_d = S_OFF;
                act_d   = C_COAST;
                cnt_d   = '0;
            end else if (state_q == S_DEAD) begin
                if (c != tgt_q) begin
                    tgt_d = c;
                    cnt_d = dead_time;
                end else if (cnt_q <= DEAD_W'(1)) begin
                    // a zero load still spends one cycle in DEAD
                    state_d = S_DRIVE;
                    act_d   = tgt_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DEAD_W'(1);
                end
            end else if (c != act_q) begin
                state_d = S_DEAD;
                tgt_d   = c;
                cnt_d   = dead_time;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= S_OFF;
                act_q   <= C_COAST;
                tgt_q   <= C_COAST;
                cnt_q   <= '0;
                pa_q    <= 1'b1;
                pb_q    <= 1'b1;
                na_q    <= 1'b0;
                nb_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                act_q   <= act_d;
                tgt_q   <= tgt_d;
                cnt_q   <= cnt_d;
                pa_q    <= (drv != C_FWD);
                pb_q    <= (drv != C_REV);
                na_q    <= (drv == C_REV) || (drv == C_BRK);
                nb_q    <= (drv == C_FWD) || (drv == C_BRK);
            end
        end

`ifdef HB_FAULT_SENSE_EN
        logic mis, mis_q, fault_q, fault_set;

        // high side on should read back 1, low side on should read back 0
        assign mis = (state_q == S_DRIVE) &&
                     ((!pa_q && !sns_a[i]) || (na_q && sns_a[i]) ||
                      (!pb_q && !sns_b[i]) || (nb_q && sns_b[i]));
        assign fault_set = mis && mis_q && !fault_q;
        assign hold      = fault_q || fault_set;

        always_ff @(posedge clock) begin
            if (reset) begin
                mis_q   <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                mis_q <= mis && !fault_q;
                if (fault_clr) begin
                    fault_q <= 1'b0;
                end else if (fault_set) begin
                    fault_q <= 1'b1;
                end
            end
        end

        assign fault[i] = fault_q;
`else
        assign hold = 1'b0;
`endif

        assign pa_n[i] = pa_q;
        assign pb_n[i] = pb_q;
        assign na[i]   = na_q;
        assign nb[i]   = nb_q;
        assign busy[i] = (state_q == S_DEAD);
    end

endmodule

// File: tb/tb_hb_bridge_array.sv
// Bench for hb_bridge_array: directed dead-time cases plus random traffic
// against a cycle-count reference model, with shoot-through monitoring.
module tb_hb_bridge_array;

    localparam int NUM_CH = 4;
    localparam int DEAD_W = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic [DEAD_W-1:0]   dead_time;
    logic [2*NUM_CH-1:0] cmd;
    logic [NUM_CH-1:0]   pa_n, pb_n, na, nb, busy;

    always #5 clock = ~clock;

`ifdef HB_FAULT_SENSE_EN
    logic [NUM_CH-1:0] sns_a, sns_b, fault;
    logic              fault_clr = 1'b0;
    assign sns_a = ~pa_n;
    assign sns_b = ~pb_n;
`endif

    hb_bridge_array #(.NUM_CH(NUM_CH), .DEAD_W(DEAD_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .dead_time (dead_time),
        .cmd       (cmd),
`ifdef HB_FAULT_SENSE_EN
        .sns_a     (sns_a),
        .sns_b     (sns_b),
        .fault_clr (fault_clr),
        .fault     (fault),
`endif
        .pa_n      (pa_n),
        .pb_n      (pb_n),
        .na        (na),
        .nb        (nb),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int busy0_cnt = 0;

    // model: mode 0 off, 1 dead, 2 drive; rem = dead cycles still to spend
    int m_mode [NUM_CH];
    int m_act  [NUM_CH];
    int m_tgt  [NUM_CH];
    int m_rem  [NUM_CH];
    logic [NUM_CH-1:0] e_pa, e_pb, e_na, e_nb;
    logic [NUM_CH-1:0] p_pa = '1, p_pb = '1, p_na = '0, p_nb = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic en,
                              input logic [DEAD_W-1:0] dt,
                              input logic [2*NUM_CH-1:0] c);
        int d, ci, span;
        logic [2*NUM_CH-1:0] cv;
        cv = c;
        span = (dt == 0) ? 1 : int'(dt);
        for (int i = 0; i < NUM_CH; i++) begin
            ci = int'(cv[2*i +: 2]);
            if (r) begin
                e_pa[i] = 1'b1; e_pb[i] = 1'b1;
                e_na[i] = 1'b0; e_nb[i] = 1'b0;
                m_mode[i] = 0; m_act[i] = 0; m_tgt[i] = 0; m_rem[i] = 0;
            end else begin
                d = (m_mode[i] == 2) ? m_act[i] : 0;
                e_pa[i] = (d != 1);
                e_pb[i] = (d != 2);
                e_na[i] = (d == 2) || (d == 3);
                e_nb[i] = (d == 1) || (d == 3);
                if (!en) begin
                    m_mode[i] = 0; m_act[i] = 0;
                end else if (m_mode[i] == 1) begin
                    if (ci != m_tgt[i]) begin
                        m_tgt[i] = ci; m_rem[i] = span;
                    end else begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_mode[i] = 2; m_act[i] = m_tgt[i];
                        end
                    end
                end else if (ci != m_act[i]) begin
                    m_mode[i] = 1; m_tgt[i] = ci; m_rem[i] = span;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e_busy, bbm;
        for (int i = 0; i < NUM_CH; i++) e_busy[i] = (m_mode[i] == 1);
        chk("pa_n", 32'(pa_n), 32'(e_pa));
        chk("pb_n", 32'(pb_n), 32'(e_pb));
        chk("na", 32'(na), 32'(e_na));
        chk("nb", 32'(nb), 32'(e_nb));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("shoot", 32'((~pa_n & na) | (~pb_n & nb)), 32'd0);
        bbm = (p_pa & ~pa_n & p_na) | (p_pb & ~pb_n & p_nb) |
              (~p_na & na & ~p_pa) | (~p_nb & nb & ~p_pb);
        chk("bbm", 32'(bbm), 32'd0);
        p_pa = pa_n; p_pb = pb_n; p_na = na; p_nb = nb;
        if (busy[0]) busy0_cnt++;
    endtask

    task automatic cycle(input logic r, input logic en,
                         input logic [DEAD_W-1:0] dt,
                         input logic [2*NUM_CH-1:0] c);
        @(negedge clock);
        check_outputs();
        reset = r; enable = en; dead_time = dt; cmd = c;
        model_step(r, en, dt, c);
    endtask

    initial begin
        logic [2*NUM_CH-1:0] rc;
        logic re, ee;
        reset = 1'b1; enable = 1'b0; dead_time = '0; cmd = '0;
        model_step(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 8'd3, 8'h00);
        chk("rst_pa", 32'(pa_n), 32'hF);
        chk("rst_n", 32'(na | nb | busy), 32'h0);
        cycle(1'b0, 1'b1, 8'd3, 8'h00);

        busy0_cnt = 0;
        repeat (6) cycle(1'b0, 1'b1, 8'd3, 8'h01);
        chk("fwd_busy", 32'(busy0_cnt), 32'd3);
        chk("fwd_gate", {30'd0, pa_n[0], nb[0]}, 32'b01);

        busy0_cnt = 0;
        repeat (8) cycle(1'b0, 1'b1, 8'd5, 8'h02);
        chk("rev_busy", 32'(busy0_cnt), 32'd5);
        chk("rev_gate", {30'd0, pb_n[0], na[0]}, 32'b01);

        busy0_cnt = 0;
        repeat (4) cycle(1'b0, 1'b1, 8'd0, 8'h03);
        chk("brk_busy", 32'(busy0_cnt), 32'd1);
        chk("brk_gate", {30'd0, na[0], nb[0]}, 32'b11);

        busy0_cnt = 0;
        repeat (3) cycle(1'b0, 1'b1, 8'd4, 8'h01);
        repeat (9) cycle(1'b0, 1'b1, 8'd4, 8'h02);
        chk("reload_busy", 32'(busy0_cnt), 32'd7);
        chk("reload_gate", {30'd0, pb_n[0], na[0]}, 32'b01);

        rc = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            re = ($urandom_range(0, 63) == 0);
            ee = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) rc = 8'($urandom);
            cycle(re, ee, 8'($urandom_range(0, 6)), rc);
        end
        cycle(1'b0, 1'b1, 8'd2, rc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hb_bridge_array.md
HB_BRIDGE_ARRAY -- requirements
Module: hb_bridge_array

Interface
- REQ-001: The block SHALL have parameter NUM_CH, default 4: number of independent H-bridge channels.
- REQ-002: The block SHALL have parameter DEAD_W, default 8: width of the dead-time count.
- REQ-003: The block SHALL have port clock, input, 1 bit: the only clock; all logic on its rising edge.
- REQ-004: The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
- REQ-005: The block SHALL have port enable, input, 1 bit: global drive enable.
- REQ-006: The block SHALL have port dead_time, input, DEAD_W bits: break-before-make interval in clock cycles.
- REQ-007: The block SHALL have port cmd, input, 2*NUM_CH bits, 2 bits per channel, channel i at [2i+1:2i]: 00 coast, 01 forward, 10 reverse, 11 brake.
- REQ-008: The block SHALL have ports pa_n and pb_n, output, NUM_CH bits each: high-side PMOS gate drives for legs A/B, active-low.
- REQ-009: The block SHALL have ports na and nb, output, NUM_CH bits each: low-side NMOS gate drives for legs A/B, active-high.
- REQ-010: The block SHALL have port busy, output, NUM_CH bits: channel i is in DEAD.

Function
- REQ-011: Each channel SHALL run an independent FSM with states OFF, DEAD and DRIVE, and SHALL hold an active_cmd register.
- REQ-012: All gate outputs SHALL be registered, and outputs SHALL reflect FSM state one cycle after the state is entered.
- REQ-013: Gate mapping in DRIVE SHALL be: forward pa_n=0, nb=1; reverse pb_n=0, na=1; brake na=nb=1; coast all off. Unlisted gates SHALL be off (p=1, n=0).
- REQ-014: In OFF and DEAD, all four gates of the channel SHALL be off (pa_n=pb_n=1, na=nb=0).
- REQ-015: Any cycle where enable=1 and a channel's cmd differs from its active_cmd SHALL move that channel to DEAD.
  - DEAD entry SHALL latch the new target and load its counter with dead_time.
  - This SHALL apply from both OFF and DRIVE.
- REQ-016: DEAD SHALL last max(dead_time,1) cycles, then move to DRIVE with active_cmd set to the latched target.
- REQ-017: A cmd change during DEAD SHALL re-latch the target and reload the counter, restarting the full interval.
- REQ-018: dead_time SHALL be sampled only at DEAD entry or reload; changes mid-count SHALL have no effect.
- REQ-019: enable=0 SHALL force every channel to OFF on the next edge and set active_cmd to 00.
  - When enable returns to 1 with cmd non-coast, the channel SHALL pass through DEAD.
- REQ-020: Under no input sequence SHALL pX_n=0 and nX=1 on the same leg in the same cycle.
- REQ-021: Under no input sequence SHALL a high-side gate change from off to on in the cycle immediately after a low-side gate on that leg was on, and vice versa.
- REQ-022: busy[i] SHALL be 1 exactly while channel i is in DEAD.

Reset
- REQ-023: On reset=1 at a clock edge, all channels SHALL go to OFF with active_cmd=00 and counters=0.
- REQ-024: On the same reset edge, outputs SHALL be pa_n=pb_n all 1, na=nb all 0, busy=0, and fault=0 when present.
- REQ-025: Reset mid-DEAD or mid-DRIVE SHALL abort the sequence with no output glitch beyond the reset values.

Configuration
- REQ-026: Macro HB_FAULT_SENSE_EN, when defined, SHALL add fault sensing.
  - Inputs sns_a and sns_b (NUM_CH bits each) carry sensed leg levels.
  - Input fault_clr (1 bit) clears faults.
  - Output fault (NUM_CH bits) reports latched faults.
- REQ-027: With HB_FAULT_SENSE_EN defined, the fault condition SHALL be a driven leg in DRIVE (high-side on expects 1, low-side on expects 0) whose sense disagrees for 2 consecutive cycles.
- REQ-028: On that condition, fault[i] SHALL latch 1 and channel i SHALL be forced to OFF.
  - The channel SHALL ignore cmd until fault_clr=1 for one cycle.
  - After clearing, the channel SHALL pass through DEAD.
- REQ-029: Without HB_FAULT_SENSE_EN, those ports and that logic SHALL be absent and the channel behaviour SHALL otherwise be identical.

Verification
- REQ-030: NUM_CH=4, dead_time=3, ch0 cmd 00->01 -> busy[0]=1 for 3 cycles, all ch0 gates off, then pa_n[0]=0, nb[0]=1; other channels unchanged.
- REQ-031: ch0 forward then cmd=10, dead_time=5 -> 5 cycles all off, then pb_n[0]=0, na[0]=1; no cycle with pa_n[0]=0 and na[0]=1.
- REQ-032: dead_time=0, cmd 00->11 -> busy for exactly 1 cycle, then na=nb=1.
- REQ-033: In DEAD with 2 cycles remaining, cmd switches 01->10 -> counter reloads and the full dead_time elapses again before reverse drive.
- REQ-034: Random cmd, enable and reset over 10k cycles with a shoot-through assertion on every leg -> zero violations.
- REQ-035: With HB_FAULT_SENSE_EN, ch1 forward and sns_a[1]=0 held 2 cycles -> fault[1]=1 and ch1 gates off; fault_clr pulse -> fault[1]=0 and a dead-time pass precedes forward.
